operand_serializer: RTL

- Upstream feeder for the bit-serial adder FSM.
- Accepts two parallel W-bit operands over a valid/ready handshake.
- Issues a one-cycle clear pulse that drives the adder's synchronous reset, then shifts both operands out LSB-first on the adder's a/b inputs. Zero padding bits are appended so the final carry emerges on the adder's stream output.
- Sequences one addition per handshake; the downstream consumer frames the result with bit_valid/done.

---
 rtl/operand_serializer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/operand_serializer.sv
// Feeds a bit-serial adder: latches an operand pair on a valid/ready handshake,
// pulses the adder clear, then streams both operands LSB-first plus PAD zero bits.
module operand_serializer #(
  parameter int W   = 8,
  parameter int PAD = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic         a,
  output logic         b,
  output logic         adder_clr,
  output logic         bit_valid,
  output logic         busy,
  output logic         done
);

  localparam int N  = W + PAD;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_CLR, S_SHIFT, S_DONE} state_t;

  state_t         r_state, w_state_nx;
  logic [CW-1:0]  r_cnt, w_cnt_nx;
  logic [W-1:0]   r_sr_a, r_sr_b, w_sr_a_nx, w_sr_b_nx;

  logic r_in_ready, r_a, r_b, r_clr, r_bv, r_busy, r_done;
  logic w_in_ready_nx, w_a_nx, w_b_nx, w_clr_nx, w_bv_nx, w_busy_nx, w_done_nx;

  // Outputs are decoded from the next state and registered, so each output
  // describes the state the block is entering on this edge.
  always_comb begin
    // NOTE: every always_comb output gets a default first; any path that
    // leaves one unassigned would otherwise infer a latch.
    w_state_nx    = r_state;
    w_cnt_nx      = r_cnt;
    w_sr_a_nx     = r_sr_a;
    w_sr_b_nx     = r_sr_b;
    w_in_ready_nx = 1'b0;
    w_a_nx        = 1'b0;
    w_b_nx        = 1'b0;
    w_clr_nx      = 1'b0;
    w_bv_nx       = 1'b0;
    w_busy_nx     = 1'b1;
    w_done_nx     = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (in_valid && r_in_ready) begin
          w_state_nx = S_CLR;
          w_sr_a_nx  = op_a;
          w_sr_b_nx  = op_b;
          w_clr_nx   = 1'b1;
        end else begin
          w_in_ready_nx = 1'b1;
          w_busy_nx     = 1'b0;
        end
      end
      S_CLR: begin
        w_state_nx = S_SHIFT;
        w_cnt_nx   = '0;
        w_a_nx     = r_sr_a[0];
        w_b_nx     = r_sr_b[0];
        w_sr_a_nx  = r_sr_a >> 1;
        w_sr_b_nx  = r_sr_b >> 1;
        w_bv_nx    = 1'b1;
      end
      S_SHIFT: begin
        if (r_cnt == LAST) begin
          w_state_nx = S_DONE;
          w_done_nx  = 1'b1;
        end else begin
          // Zero fill turns the tail of the stream into the PAD bits.
          w_cnt_nx  = r_cnt + CW'(1);
          w_a_nx    = r_sr_a[0];
          w_b_nx    = r_sr_b[0];
          w_sr_a_nx = r_sr_a >> 1;
          w_sr_b_nx = r_sr_b >> 1;
          w_bv_nx   = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nx    = S_IDLE;
        w_in_ready_nx = 1'b1;
        w_busy_nx     = 1'b0;
      end
      default: begin
        w_state_nx    = S_IDLE;
        w_in_ready_nx = 1'b1;
        w_busy_nx     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_sr_a     <= '0;
      r_sr_b     <= '0;
      r_in_ready <= 1'b1;
      r_a        <= 1'b0;
      r_b        <= 1'b0;
      r_clr      <= 1'b0;
      r_bv       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples the pre-edge values regardless of statement order.
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_sr_a     <= w_sr_a_nx;
      r_sr_b     <= w_sr_b_nx;
      r_in_ready <= w_in_ready_nx;
      r_a        <= w_a_nx;
      r_b        <= w_b_nx;
      r_clr      <= w_clr_nx;
      r_bv       <= w_bv_nx;
      r_busy     <= w_busy_nx;
      r_done     <= w_done_nx;
    end
  end

  assign in_ready  = r_in_ready;
  assign a         = r_a;
  assign b         = r_b;
  assign adder_clr = r_clr;
  assign bit_valid = r_bv;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
